// File: rtl/noc_out_arbiter.sv
// rtl/noc_out_arbiter.sv - round-robin merge of N_IN switch outputs into one link through a DEPTH-entry FIFO
// Optional per-input saturating grant counters on grant_cnt when NOC_ARB_STATS_EN is defined.
module noc_out_arbiter #(
    parameter int WIDTH = 39,
    parameter int N_IN  = 4,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [N_IN*16-1:0]      grant_cnt
`endif
);

    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gnt_idx;
    logic [PW:0]      scan;
    logic [N_IN-1:0]  grant;
    logic             space;
    logic             push;
    logic             pop;

    // No bypass: a full FIFO refuses pushes even while it is being popped.
    assign space = (count < (AW+1)'(DEPTH));

    // Walk the scan order backwards so the earliest valid input from rr_ptr wins by overwrite.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        scan    = '0;
        if (space) begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                scan = {1'b0, rr_ptr} + (PW+1)'(k);
                if (scan >= (PW+1)'(N_IN))
                    scan = scan - (PW+1)'(N_IN);
                if (in_valid[scan[PW-1:0]]) begin
                    grant                 = '0;
                    grant[scan[PW-1:0]]   = 1'b1;
                    gnt_idx               = scan[PW-1:0];
                end
            end
        end
    end

    assign in_ready  = grant;
    assign push      = |grant;
    assign out_valid = (count != '0);
    assign out_data  = mem[rptr];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rr_ptr <= '0;
            for (int d = 0; d < DEPTH; d++)
                mem[d] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                wptr      <= wptr + 1'b1;
                rr_ptr    <= (gnt_idx == PW'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef NOC_ARB_STATS_EN
    logic [N_IN-1:0][15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++)
                if (grant[i] && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// tb/tb_noc_out_arbiter.sv - scoreboard bench for noc_out_arbiter with a queue-based reference model
module tb_noc_out_arbiter;
    localparam int W = 39;
    localparam int N = 4;
    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
`ifdef NOC_ARB_STATS_EN
    logic [N*16-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    noc_out_arbiter #(.WIDTH(W), .N_IN(N), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef NOC_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int           checks = 0;
    int           passes = 0;
    logic [W-1:0] sb[$];
    bit           pv[N];
    logic [W-1:0] pd[N];
    bit           refill = 1'b0;
    int           mcount = 0;
    int           mrr = 0;
    int           last_g = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            in_valid[i]       = pv[i];
            in_data[i*W +: W] = pd[i];
        end
    endtask

    // One clock of stimulus; the model decides the grant from pending sources, count and rr pointer.
    task automatic step(input bit ordy);
        int  g;
        bit  p;
        logic [N-1:0] exp_rdy;
        @(posedge clk);
        #1;
        out_ready = ordy;
        apply();
        #1;
        g = -1;
        if (mcount < D)
            for (int k = 0; k < N; k++)
                if (g < 0 && pv[(mrr + k) % N]) g = (mrr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, mcount > 0);
        p = (mcount > 0) && ordy;
        if (g >= 0) begin
            sb.push_back(pd[g]);
            mrr = (g + 1) % N;
            if (!refill) pv[g] = 1'b0;
        end
        mcount = mcount + (g >= 0 ? 1 : 0) - (p ? 1 : 0);
        last_g = g;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        apply();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        sb.delete();
        mcount = 0;
        mrr    = 0;
        refill = 1'b0;
        rst_n  = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("out_data", out_data, sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        #12;
        check("init_out_valid", out_valid, 0);
        check("init_in_ready", in_ready, 0);
        check("init_out_data", out_data, 0);
        #1 rst_n = 1'b1;

        // Single packet then rr_ptr at 3
        pv[2] = 1'b1; pd[2] = 39'h22222_0001;
        step(1'b1);
        check("single_rdy", in_ready, 4'b0100);
        step(1'b1);
        check("single_vld", out_valid, 1);
        check("single_data", out_data, 39'h22222_0001);
        pv[0] = 1'b1; pd[0] = 39'h0; pv[3] = 1'b1; pd[3] = 39'h3;
        step(1'b1);
        check("rr_after_single", in_ready, 4'b1000);
        repeat (4) step(1'b1);

        // Round robin with all inputs continuously valid
        reset_pulse();
        refill = 1'b1;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b1;
            pd[i] = W'(8'hA0 + i);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            check("rr_grant", last_g, k % N);
        end
        refill = 1'b0;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        repeat (3) step(1'b1);

        // Backpressure to full, then single pop
        reset_pulse();
        refill = 1'b1;
        pv[1] = 1'b1; pd[1] = 39'h11111_0001;
        pv[3] = 1'b1; pd[3] = 39'h33333_0003;
        step(1'b0); check("bp_g1", last_g, 1);
        step(1'b0); check("bp_g3", last_g, 3);
        step(1'b0); check("bp_full", in_ready, 0);
        check("bp_head", out_data, 39'h11111_0001);
        step(1'b1); check("bp_nobypass", in_ready, 0);
        step(1'b0); check("bp_next", last_g, 1);
        refill = 1'b0;
        pv[1] = 1'b0; pv[3] = 1'b0;
        repeat (4) step(1'b1);

        // Full with simultaneous pop
        reset_pulse();
        pv[0] = 1'b1; pd[0] = 39'h0A;
        pv[1] = 1'b1; pd[1] = 39'h1B;
        step(1'b0);
        step(1'b0);
        pv[0] = 1'b1; pd[0] = 39'h0C;
        step(1'b1); check("fp_nogrant", in_ready, 0);
        step(1'b0); check("fp_grant", in_ready, 4'b0001);
        repeat (3) step(1'b1);

        // Reset mid-operation with count 2 and rr_ptr 2
        reset_pulse();
        pv[0] = 1'b1; pd[0] = 39'h5;
        pv[1] = 1'b1; pd[1] = 39'h6;
        step(1'b0);
        step(1'b0);
        reset_pulse();
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b1;
            pd[i] = W'(i + 9);
        end
        step(1'b1);
        check("midrst_grant", last_g, 0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(1) == 1) begin
                    pv[i] = 1'b1;
                    pd[i] = W'({$urandom, $urandom});
                end
            step($urandom_range(3) != 0);
        end
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        repeat (4) step(1'b1);
        check("drain_empty", out_valid, 0);

`ifdef NOC_ARB_STATS_EN
        reset_pulse();
        check("stats_rst", grant_cnt, 0);
        refill = 1'b1;
        pv[2] = 1'b1; pd[2] = 39'h2;
        repeat (70000) step(1'b1);
        check("stats_sat", grant_cnt[47:32], 16'hFFFF);
        check("stats_others", {grant_cnt[63:48], grant_cnt[31:0]}, 0);
        refill = 1'b0;
        pv[2] = 1'b0;
        repeat (3) step(1'b1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
- Output-port stage of the NoC router; sits directly downstream of the per-input routing switches.
- Merges the N_IN switch outputs that target one router output direction into that direction's single outgoing link.
- Example: the toDown outputs of the up, left, right and local switches feed the Down arbiter.
- Round-robin arbitration, valid/ready handshakes, DEPTH-entry output FIFO; packets pass through unmodified.

Parameters:
- WIDTH, 39, packet width; routing fields unused here (x at [36:33], y at [32:29]).
- N_IN, 4, number of competing switch inputs; index 0 has highest priority after reset.
- DEPTH, 2, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N_IN  per-input packet valid.
- in_data  input  N_IN*WIDTH  flattened packets; input i occupies [i*WIDTH +: WIDTH].
- in_ready  output  N_IN  one-hot-or-zero grant; a transfer occurs when in_valid[i] & in_ready[i].
- out_valid  output  1  FIFO head valid.
- out_data  output  WIDTH  FIFO head packet.
- out_ready  input  1  downstream link accepts the head this cycle.

Behaviour:
- Reset (async assert, sync release):
  - FIFO count = 0, read/write pointers = 0, rr_ptr = 0.
  - out_valid = 0, out_data = 0, in_ready = 0.
- Space:
  - space = (count < DEPTH).
  - No bypass: when full, a pop in the same cycle does not free a slot for a push.
- Arbitration (combinational, same cycle):
  - If space, scan inputs starting at rr_ptr, wrapping modulo N_IN.
  - The first i with in_valid[i] gets in_ready[i] = 1; all other ready bits are 0.
  - With no space, or no valid input, in_ready = 0.
- On a grant to input i:
  - Write in_data[i] at the write pointer, which then wraps modulo DEPTH.
  - rr_ptr <= (i+1) mod N_IN.
  - rr_ptr holds when nothing is granted.
- Pop:
  - out_valid & out_ready advances the read pointer.
  - out_data is the registered head entry; it is stable while out_valid & !out_ready.
- Count:
  - push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Simultaneous push and pop is legal whenever count is between 1 and DEPTH-1.
- Latency:
  - A packet accepted into an empty FIFO in cycle N is visible with out_valid = 1 in cycle N+1.
  - Sustained throughput is 1 packet/cycle when out_ready is held high.
- Source protocol:
  - A source holds in_valid and in_data stable until its transfer completes.
  - The arbiter never drops or duplicates a packet.
- Fairness: with all N_IN inputs continuously valid and no backpressure, grants rotate 0,1,..,N_IN-1,0,...
- Reset mid-operation: FIFO contents are discarded, out_valid drops immediately, and rr_ptr returns to 0.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- When defined:
  - Adds output port grant_cnt (N_IN*16 bits).
  - Holds one 16-bit saturating counter per input, incremented on each granted transfer; it sticks at 16'hFFFF.
  - Counters reset to 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single packet:
  - Stimulus: after reset, in_valid = 4'b0100, in_data[2] = 39'h22222_0001, out_ready = 1.
  - Response: in_ready = 4'b0100 that cycle; out_valid = 1 with out_data = 39'h22222_0001 next cycle; rr_ptr = 3.
- Round-robin:
  - Stimulus: all four inputs valid continuously, packets tagged 0xA0..0xA3, out_ready = 1.
  - Response: grant order 0,1,2,3,0 on consecutive cycles; output sequence A0,A1,A2,A3,A0.
- Backpressure to full:
  - Stimulus: out_ready = 0, inputs 1 and 3 valid.
  - Response: two packets accepted (1 then 3), then in_ready = 0.
  - out_data stays at input 1's packet.
  - With out_ready = 1 for one cycle, the head pops and the next grant goes to input 1 (rr_ptr = 0, input 0 idle).
- Full with simultaneous pop:
  - Stimulus: count = 2, out_ready = 1, input 0 valid.
  - Response: no grant that cycle; grant occurs the following cycle; count sequence 2,1,2.
- Mid-operation reset:
  - Stimulus: count = 2, rr_ptr = 2; pulse rst_n low between clock edges.
  - Response: out_valid = 0 immediately.
  - After release, the first grant with all inputs valid goes to input 0.
- Stats (with NOC_ARB_STATS_EN defined):
  - Stimulus: 70000 grants to input 2.
  - Response: grant_cnt[47:32] = 16'hFFFF; other counters = 0.
